// File: rtl/io_strobe_gen.sv
// -----------------------------------------------------------------------------
// io_strobe_gen
// I/O strobe sequencer for the Slipstream I/O decode path. It accepts a CPU I/O
// request on the rising edge of io_req and checks that the decoded device
// select is exactly one-hot. It then drives one registered read or write
// strobe, which has a setup cycle, a programmable width and a hold/ready cycle.
// A request whose select is zero or multi-hot gets a one-cycle ready+error
// reply instead.
//
// Optional feature macro: IOSTB_TIMEOUT_EN
//   When defined, a watchdog aborts a strobe that has lasted TMO cycles. The
//   abort sends the block through the error reply.
//
// Parameters:
//   NDEV   number of decoded devices (width of select / strobe vectors)
//   WAITW  width of the wait-state count
//   TMO    watchdog limit in cycles (IOSTB_TIMEOUT_EN builds only)
//
// Ports:
//   MasterClock  in   system clock, rising edge
//   nRESET       in   asynchronous active-low reset
//   io_req       in   CPU I/O request level, held until io_rdy
//   io_wr        in   1 = write, 0 = read (sampled at acceptance)
//   dev_sel      in   one-hot device select (sampled at acceptance)
//   wait_cfg     in   extra strobe cycles (sampled at acceptance)
//   io_hold      in   device strobe-extend request
//   rd_stb       out  registered read strobes
//   wr_stb       out  registered write strobes
//   io_rdy       out  one-cycle completion pulse
//   io_err       out  one-cycle error flag, only together with io_rdy
//   o_dbg_state  out  current sequencer state (debug observation)
//
// Handshake: io_req acts as a level "valid". A transaction starts only on the
// IDLE cycle where io_req is 1 and was 0 on the previous sample. io_rdy is the
// one-cycle "done" reply. The requester must hold io_req until io_rdy, and it
// must drop io_req for at least one cycle before it can start another
// transaction.
// -----------------------------------------------------------------------------
module io_strobe_gen #(
  parameter int NDEV  = 8,
  parameter int WAITW = 4
`ifdef IOSTB_TIMEOUT_EN
  ,
  parameter int TMO   = 64
`endif
) (
  input  logic             MasterClock,
  input  logic             nRESET,
  input  logic             io_req,
  input  logic             io_wr,
  input  logic [NDEV-1:0]  dev_sel,
  input  logic [WAITW-1:0] wait_cfg,
  input  logic             io_hold,
  output logic [NDEV-1:0]  rd_stb,
  output logic [NDEV-1:0]  wr_stb,
  output logic             io_rdy,
  output logic             io_err,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_req_q;
  logic [NDEV-1:0]  r_sel;
  logic             r_wr;
  logic [WAITW-1:0] r_wait;
  logic [WAITW-1:0] r_cnt;
  logic [NDEV-1:0]  r_rd_stb;
  logic [NDEV-1:0]  r_wr_stb;
  logic             r_rdy;
  logic             r_err;

  logic w_accept;
  logic w_onehot;
  logic w_tmo;

  // The rising edge of io_req arms acceptance, so a level held across a
  // completion never starts a second cycle.
  assign w_accept = io_req && !r_req_q;

  // A value is one-hot when it is nonzero and clearing its lowest set bit
  // leaves zero.
  assign w_onehot = (dev_sel != '0) && ((dev_sel & (dev_sel - NDEV'(1))) == '0);

`ifdef IOSTB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] r_wdog;

  // r_wdog holds (cycles spent in STROBE - 1) at each STROBE edge.
  assign w_tmo = (r_state == S_STROBE) && (r_wdog == TW'(TMO - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge MasterClock or negedge nRESET) begin
    if (!nRESET) begin
      r_state  <= S_IDLE;
      r_req_q  <= 1'b0;
      r_sel    <= '0;
      r_wr     <= 1'b0;
      r_wait   <= '0;
      r_cnt    <= '0;
      r_rd_stb <= '0;
      r_wr_stb <= '0;
      r_rdy    <= 1'b0;
      r_err    <= 1'b0;
`ifdef IOSTB_TIMEOUT_EN
      r_wdog   <= '0;
`endif
    end else begin
      r_req_q <= io_req;
      // io_rdy / io_err are single-cycle pulses; only the exit edges set them.
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
`ifdef IOSTB_TIMEOUT_EN
      r_wdog  <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_onehot) begin
              r_sel   <= dev_sel;
              r_wr    <= io_wr;
              r_wait  <= wait_cfg;
              r_state <= S_SETUP;
            end else begin
              r_rdy   <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_SETUP: begin
          r_cnt   <= r_wait;
          r_state <= S_STROBE;
          if (r_wr) r_wr_stb <= r_sel;
          else      r_rd_stb <= r_sel;
        end
        S_STROBE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - WAITW'(1);
`ifdef IOSTB_TIMEOUT_EN
          r_wdog <= r_wdog + TW'(1);
`endif
          if (w_tmo) begin
            // The watchdog wins over io_hold and over a normal exit on the
            // same edge.
            r_rd_stb <= '0;
            r_wr_stb <= '0;
            r_rdy    <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= S_ERR;
          end else if ((r_cnt == '0) && !io_hold) begin
            r_rd_stb <= '0;
            r_wr_stb <= '0;
            r_rdy    <= 1'b1;
            r_state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_rd_stb <= '0;
          r_wr_stb <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_stb      = r_rd_stb;
  assign wr_stb      = r_wr_stb;
  assign io_rdy      = r_rdy;
  assign io_err      = r_err;
  assign o_dbg_state = r_state;

endmodule
